// File: rtl/f2i_iter.sv
// rtl/f2i_iter.sv - sequential single-precision float to signed integer converter
module f2i_iter #(
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_invalid,
  output logic                 out_inexact
);

  localparam int W = OUT_WIDTH;

  // Biased exponent thresholds: 127 is E=0, 150 puts the hidden-bit mantissa
  // exactly in place (E=23), 126+W is the first exponent that cannot fit.
  localparam logic [7:0] E_BIAS    = 8'd127;
  localparam logic [7:0] E_MANT    = 8'd150;
  localparam logic [7:0] E_TOP     = 8'(126 + W);
  localparam logic [4:0] E_MANT_LO = E_MANT[4:0];

  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [4:0]   cnt;
  logic [W-1:0] work;
  logic         left;
  logic         neg;
  logic         sticky;
  logic         inv;

  logic         dec_s;
  logic [7:0]   dec_e;
  logic [22:0]  dec_f;
  logic [W-1:0] dec_work;
  logic [4:0]   dec_cnt;
  logic         dec_left;
  logic         dec_neg;
  logic         dec_sticky;
  logic         dec_inv;

  assign dec_s    = in_data[31];
  assign dec_e    = in_data[30:23];
  assign dec_f    = in_data[22:0];
  assign in_ready = (state == IDLE);

  // Classify the incoming float; special cases load their final value into
  // the work register with a zero shift count so they share the output path.
  always_comb begin
    dec_work   = '0;
    dec_cnt    = '0;
    dec_left   = 1'b0;
    dec_neg    = 1'b0;
    dec_sticky = 1'b0;
    dec_inv    = 1'b0;
    if (dec_e == 8'hFF) begin
      dec_inv = 1'b1;
      if (dec_f != 23'd0) begin
        dec_work = MAX_POS;
      end else begin
        dec_work = dec_s ? MAX_NEG : MAX_POS;
      end
    end else if (dec_e < E_BIAS) begin
      dec_sticky = |in_data[30:0];
    end else if (dec_e >= E_TOP) begin
      if (dec_s && (dec_e == E_TOP) && (dec_f == 23'd0)) begin
        dec_work = MAX_NEG;
      end else begin
        dec_inv  = 1'b1;
        dec_work = dec_s ? MAX_NEG : MAX_POS;
      end
    end else begin
      dec_work = W'({1'b1, dec_f});
      dec_neg  = dec_s;
      // Only the low five bits matter: the distance never exceeds 23.
      if (dec_e > E_MANT) begin
        dec_left = 1'b1;
        dec_cnt  = dec_e[4:0] - E_MANT_LO;
      end else begin
        dec_cnt  = E_MANT_LO - dec_e[4:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, finish SHIFT when the count is spent,
  // leave OUT only when the consumer takes the result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (cnt == 5'd0) state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch decode, shift one bit per cycle, then present and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      work        <= '0;
      left        <= 1'b0;
      neg         <= 1'b0;
      sticky      <= 1'b0;
      inv         <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_invalid <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt    <= dec_cnt;
            work   <= dec_work;
            left   <= dec_left;
            neg    <= dec_neg;
            sticky <= dec_sticky;
            inv    <= dec_inv;
          end
        end
        SHIFT: begin
          if (cnt != 5'd0) begin
            cnt <= cnt - 5'd1;
            if (left) begin
              work <= work << 1;
            end else begin
              work   <= work >> 1;
              sticky <= sticky | work[0];
            end
          end else begin
            out_data    <= neg ? -work : work;
            out_valid   <= 1'b1;
            out_invalid <= inv;
            out_inexact <= sticky;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            out_invalid <= 1'b0;
            out_inexact <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
